stopwatch_ctrl: RTL and testbench

Control unit for the two-digit BCD stopwatch. It synchronises and debounces the four push-buttons, converts each press into a one-cycle press pulse, and runs the run/pause/clear state machine. It owns the seconds prescaler and issues increment and clear strobes to the BCD counter datapath. It also reads back the counter value so it can stop at full scale.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/button_debounce.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

  // One-hot control states; the encoding is visible on fsm_state.
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    RUN_ONE = 5'b00010,
    RUN_TEN = 5'b00100,
    PAUSED  = 5'b01000,
    CLEAR   = 5'b10000
  } state_t;

  // Full-scale values of the two-digit BCD counter.
  localparam logic [7:0] BCD_MAX  = 8'h99;
  localparam logic [3:0] TENS_MAX = 4'h9;

  // Defaults sized for a 10 MHz core clock.
  localparam int DEF_TICK_CYCLES     = 10_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 100_000;

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw button, debounces it and emits a one-cycle press pulse on an accepted rise.
// Latency: raw edge to press pulse is 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; the pulse is lost if the consumer ignores it.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has been seen DEBOUNCE_CYCLES samples in a row;
  // any disagreeing sample restarts the count. Only accepted rises produce a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear control for the two-digit BCD stopwatch: button conditioning, prescaler, strobes.
// Latency: press pulse to state change 1 cycle; strobes are combinational from registered state.
// Backpressure: none; strobes are fire-and-forget, the datapath must accept every one.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STOP_AT_MAX     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_button,
  input  logic       ten_button,
  input  logic       pause_button,
  input  logic       clear_button,
  input  logic [7:0] bcd_num,
  output logic       inc_one,
  output logic       inc_ten,
  output logic       clear_count,
  output logic       at_max,
  output logic [4:0] fsm_state
);

  localparam int PW = $clog2(TICK_CYCLES + 1);

  logic          one_press;
  logic          ten_press;
  logic          pause_press;
  logic          clear_press;
  state_t        state;
  state_t        state_nxt;
  state_t        last_mode;
  state_t        last_mode_nxt;
  logic          at_max_nxt;
  logic [PW-1:0] presc;
  logic          running;
  logic          tick;
  logic          full;
  logic          stop_hit;
  logic          inc_one_c;
  logic          inc_ten_c;
  logic          clear_c;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
    .clk(clk), .rst(rst), .btn_raw(one_button), .press(one_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ten (
    .clk(clk), .rst(rst), .btn_raw(ten_button), .press(ten_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .rst(rst), .btn_raw(pause_button), .press(pause_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .btn_raw(clear_button), .press(clear_press)
  );

  assign running  = (state == RUN_ONE) || (state == RUN_TEN);
  assign tick     = running && (presc == PW'(TICK_CYCLES - 1));
  assign full     = (state == RUN_ONE) ? (bcd_num == BCD_MAX) : (bcd_num[7:4] == TENS_MAX);
  assign stop_hit = tick && (STOP_AT_MAX != 0) && full;

  // Prescaler only advances while running, so a pause keeps the partial second.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (state == CLEAR) begin
      presc <= '0;
    end else if (running) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // State, resume target and full-scale flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_mode <= RUN_ONE;
      at_max    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_mode <= last_mode_nxt;
      at_max    <= at_max_nxt;
    end
  end

  // Next state and strobes; press priority is clear > pause > one > ten.
  always_comb begin
    state_nxt     = state;
    last_mode_nxt = last_mode;
    at_max_nxt    = at_max;
    inc_one_c     = 1'b0;
    inc_ten_c     = 1'b0;
    clear_c       = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_press)    state_nxt = CLEAR;
        else if (one_press) state_nxt = RUN_ONE;
        else if (ten_press) state_nxt = RUN_TEN;
      end
      RUN_ONE, RUN_TEN: begin
        if (clear_press) begin
          state_nxt = CLEAR;
        end else if (stop_hit) begin
          // Full scale: swallow the strobe and park, only clear can leave.
          at_max_nxt    = 1'b1;
          last_mode_nxt = state;
          state_nxt     = PAUSED;
        end else begin
          // Strobe follows the registered mode even if the mode changes this cycle.
          if (tick) begin
            if (state == RUN_ONE) inc_one_c = 1'b1;
            else                  inc_ten_c = 1'b1;
          end
          if (pause_press) begin
            last_mode_nxt = state;
            state_nxt     = PAUSED;
          end else if (one_press) begin
            state_nxt = RUN_ONE;
          end else if (ten_press) begin
            state_nxt = RUN_TEN;
          end
        end
      end
      PAUSED: begin
        if (clear_press)                state_nxt = CLEAR;
        else if (at_max)                state_nxt = PAUSED;
        else if (pause_press)           state_nxt = last_mode;
        else if (one_press)             state_nxt = RUN_ONE;
        else if (ten_press)             state_nxt = RUN_TEN;
      end
      CLEAR: begin
        clear_c       = 1'b1;
        at_max_nxt    = 1'b0;
        last_mode_nxt = RUN_ONE;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes are held off while reset is asserted.
  assign inc_one     = inc_one_c & ~rst;
  assign inc_ten     = inc_ten_c & ~rst;
  assign clear_count = clear_c & ~rst;
  assign fsm_state   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD counter on bcd_num.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_ctrl;

  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_RUN_ONE = 5'b00010;
  localparam logic [4:0] S_RUN_TEN = 5'b00100;
  localparam logic [4:0] S_PAUSED  = 5'b01000;
  localparam logic [4:0] S_CLEAR   = 5'b10000;

  localparam logic [3:0] B_ONE   = 4'b0001;
  localparam logic [3:0] B_TEN   = 4'b0010;
  localparam logic [3:0] B_PAUSE = 4'b0100;
  localparam logic [3:0] B_CLR   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [7:0] bcd_num;
  logic       inc_one;
  logic       inc_ten;
  logic       clear_count;
  logic       at_max;
  logic [4:0] fsm_state;
  logic       pre_req = 1'b0;
  logic [7:0] pre_val = 8'h00;
  int         errors = 0;
  int         checks = 0;

  stopwatch_ctrl #(.TICK_CYCLES(100), .DEBOUNCE_CYCLES(4), .STOP_AT_MAX(1)) dut (
    .clk(clk), .rst(rst),
    .one_button(btn[0]), .ten_button(btn[1]), .pause_button(btn[2]), .clear_button(btn[3]),
    .bcd_num(bcd_num), .inc_one(inc_one), .inc_ten(inc_ten), .clear_count(clear_count),
    .at_max(at_max), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_add(input logic [7:0] v, input logic by_ten);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (!by_ten) begin
      if (o == 4'd9) begin
        o = 4'd0;
        t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
        o = o + 4'd1;
      end
    end else begin
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end
    return {t, o};
  endfunction

  // BCD counter datapath model, with a preload hook for full-scale scenarios.
  always @(posedge clk) begin
    if (rst)              bcd_num <= 8'h00;
    else if (pre_req)     bcd_num <= pre_val;
    else if (clear_count) bcd_num <= 8'h00;
    else if (inc_one)     bcd_num <= bcd_add(bcd_num, 1'b0);
    else if (inc_ten)     bcd_num <= bcd_add(bcd_num, 1'b1);
  end

  task automatic wait_state(input logic [4:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fsm_state === st) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_inc_one(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inc_one === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    pre_val = v;
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (fsm_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %b expected %b", fsm_state, S_IDLE);
    end
    checks++;
    if ({inc_one, inc_ten, clear_count, at_max} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {inc_one, inc_ten, clear_count, at_max});
    end
  endtask

  task automatic test_run_one;
    bit ok;
    int n = 0, first = -1, last = -1, other = 0;
    btn = B_ONE;
    wait_state(S_RUN_ONE, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL run_one_enter: got %b expected %b", fsm_state, S_RUN_ONE); end
    for (int i = 0; i < 500; i++) begin
      if (i == 13) btn = 4'b0000;
      if (inc_one === 1'b1) begin
        if (n == 0) begin
          first = i;
        end else begin
          checks++;
          if (i - last !== 100) begin
            errors++; $display("FAIL run_one_spacing: got %0d expected 100", i - last);
          end
        end
        last = i;
        n++;
      end
      if (inc_ten === 1'b1 || clear_count === 1'b1) other++;
      @(negedge clk);
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL run_one_count: got %0d expected 5", n); end
    checks++;
    if (first !== 99) begin errors++; $display("FAIL run_one_first: got %0d expected 99", first); end
    checks++;
    if (other !== 0) begin errors++; $display("FAIL run_one_other_strobes: got %0d expected 0", other); end
    checks++;
    if (fsm_state !== S_RUN_ONE) begin errors++; $display("FAIL run_one_state: got %b expected %b", fsm_state, S_RUN_ONE); end
    checks++;
    if (bcd_num !== 8'h05) begin errors++; $display("FAIL run_one_bcd: got %h expected 05", bcd_num); end
  endtask

  // Entered one cycle after the last tick; pause lands 60 run cycles after that tick.
  task automatic test_pause_resume;
    bit ok;
    int j = 0, strobes = 0, bad_state = 0, n = 1;
    repeat (53) @(negedge clk);
    btn = B_PAUSE;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (fsm_state === S_PAUSED) begin
        j = k;
        break;
      end
    end
    checks++;
    if (j !== 7) begin errors++; $display("FAIL pause_latency: got %0d expected 7", j); end
    for (int i = 0; i < 500; i++) begin
      if (i == 13) btn = 4'b0000;
      if (inc_one === 1'b1 || inc_ten === 1'b1 || clear_count === 1'b1) strobes++;
      if (fsm_state !== S_PAUSED) bad_state++;
      @(negedge clk);
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL paused_strobes: got %0d expected 0", strobes); end
    checks++;
    if (bad_state !== 0) begin errors++; $display("FAIL paused_hold: got %0d expected 0", bad_state); end
    btn = B_PAUSE;
    wait_state(S_RUN_ONE, 30, ok);
    btn = 4'b0000;
    checks++;
    if (!ok) begin errors++; $display("FAIL resume_state: got %b expected %b", fsm_state, S_RUN_ONE); end
    while (inc_one !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 40) begin errors++; $display("FAIL resume_partial_tick: got %0d expected 40", n); end
    @(negedge clk);
    checks++;
    if (bcd_num !== 8'h06) begin errors++; $display("FAIL resume_bcd: got %h expected 06", bcd_num); end
  endtask

  task automatic test_run_ten;
    bit ok;
    int n_ten = 0, n_one = 0;
    btn = B_PAUSE;
    wait_state(S_PAUSED, 30, ok);
    btn = 4'b0000;
    checks++;
    if (!ok) begin errors++; $display("FAIL ten_pause: got %b expected %b", fsm_state, S_PAUSED); end
    preload(8'h05);
    repeat (10) @(negedge clk);
    btn = B_TEN;
    wait_state(S_RUN_TEN, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ten_enter: got %b expected %b", fsm_state, S_RUN_TEN); end
    for (int i = 0; i < 300; i++) begin
      if (i == 10) btn = 4'b0000;
      if (inc_ten === 1'b1) n_ten++;
      if (inc_one === 1'b1) n_one++;
      @(negedge clk);
    end
    checks++;
    if (n_ten !== 3) begin errors++; $display("FAIL ten_count: got %0d expected 3", n_ten); end
    checks++;
    if (n_one !== 0) begin errors++; $display("FAIL ten_no_inc_one: got %0d expected 0", n_one); end
    checks++;
    if (fsm_state !== S_RUN_TEN) begin errors++; $display("FAIL ten_state: got %b expected %b", fsm_state, S_RUN_TEN); end
    checks++;
    if (bcd_num !== 8'h35) begin errors++; $display("FAIL ten_bcd: got %h expected 35", bcd_num); end
  endtask

  task automatic test_full_scale;
    bit ok;
    int pj = 0, strobes = 0;
    btn = B_ONE;
    wait_state(S_RUN_ONE, 30, ok);
    btn = 4'b0000;
    checks++;
    if (!ok) begin errors++; $display("FAIL max_switch: got %b expected %b", fsm_state, S_RUN_ONE); end
    wait_inc_one(120, ok);
    @(negedge clk);
    preload(8'h98);
    wait_inc_one(120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL max_last_inc: got %b expected 1", inc_one); end
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (inc_one === 1'b1 || inc_ten === 1'b1 || clear_count === 1'b1) strobes++;
      if (fsm_state === S_PAUSED && pj == 0) pj = k;
    end
    checks++;
    if (pj !== 101) begin errors++; $display("FAIL max_pause_cycle: got %0d expected 101", pj); end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL max_no_strobe: got %0d expected 0", strobes); end
    checks++;
    if (at_max !== 1'b1) begin errors++; $display("FAIL max_flag: got %b expected 1", at_max); end
    checks++;
    if (bcd_num !== 8'h99) begin errors++; $display("FAIL max_bcd: got %h expected 99", bcd_num); end
    strobes = 0;
    btn = B_ONE;
    for (int i = 0; i < 25; i++) begin
      if (i == 15) btn = 4'b0000;
      if (inc_one === 1'b1 || inc_ten === 1'b1) strobes++;
      @(negedge clk);
    end
    checks++;
    if ({fsm_state, at_max} !== {S_PAUSED, 1'b1}) begin
      errors++; $display("FAIL max_ignore_one: got %b/%b expected %b/1", fsm_state, at_max, S_PAUSED);
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL max_ignore_strobe: got %0d expected 0", strobes); end
  endtask

  task automatic test_clear_priority(input logic from_run);
    bit ok;
    if (from_run) begin
      btn = B_ONE;
      wait_state(S_RUN_ONE, 30, ok);
      btn = 4'b0000;
      repeat (20) @(negedge clk);
    end
    btn = B_CLR | B_PAUSE;
    wait_state(S_CLEAR, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clear_enter: got %b expected %b", fsm_state, S_CLEAR); end
    checks++;
    if ({clear_count, inc_one, inc_ten} !== 3'b100) begin
      errors++; $display("FAIL clear_strobe: got %b expected 100", {clear_count, inc_one, inc_ten});
    end
    @(negedge clk);
    btn = 4'b0000;
    checks++;
    if ({fsm_state, clear_count, at_max} !== {S_IDLE, 2'b00}) begin
      errors++; $display("FAIL clear_exit: got %b/%b/%b expected %b/0/0", fsm_state, clear_count, at_max, S_IDLE);
    end
    checks++;
    if (bcd_num !== 8'h00) begin errors++; $display("FAIL clear_bcd: got %h expected 00", bcd_num); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_idle_pause_ignored;
    btn = B_PAUSE;
    repeat (15) @(negedge clk);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
    checks++;
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL idle_pause: got %b expected %b", fsm_state, S_IDLE); end
  endtask

  task automatic test_bounce;
    bit ok;
    logic [21:0] pat;
    logic [4:0]  prev;
    int changes = 0;
    pat = 22'b1110111011101111111111;
    btn = B_ONE;
    wait_state(S_RUN_ONE, 30, ok);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
    prev = fsm_state;
    for (int i = 0; i < 42; i++) begin
      btn = (i < 22 && pat[21-i]) ? B_PAUSE : 4'b0000;
      @(negedge clk);
      if (fsm_state !== prev) begin
        changes++;
        prev = fsm_state;
      end
    end
    checks++;
    if (changes !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", changes); end
    checks++;
    if (fsm_state !== S_PAUSED) begin errors++; $display("FAIL bounce_state: got %b expected %b", fsm_state, S_PAUSED); end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    btn = B_PAUSE;
    wait_state(S_RUN_ONE, 30, ok);
    btn = 4'b0000;
    wait_inc_one(120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_run_tick: got %b expected 1", inc_one); end
    repeat (100) @(negedge clk);
    checks++;
    if (inc_one !== 1'b1) begin errors++; $display("FAIL rst_pre_tick: got %b expected 1", inc_one); end
    rst = 1'b1;
    #1;
    checks++;
    if ({inc_one, inc_ten, clear_count} !== 3'b000) begin
      errors++; $display("FAIL rst_cycle_strobes: got %b expected 000", {inc_one, inc_ten, clear_count});
    end
    @(negedge clk);
    checks++;
    if ({fsm_state, inc_one, inc_ten, clear_count, at_max} !== {S_IDLE, 4'b0000}) begin
      errors++; $display("FAIL rst_after: got %b expected %b0000", {fsm_state, inc_one, inc_ten, clear_count, at_max}, S_IDLE);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL rst_stays_idle: got %b expected %b", fsm_state, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_run_one();
    test_pause_resume();
    test_run_ten();
    test_full_scale();
    test_clear_priority(1'b0);
    test_idle_pause_ignored();
    test_clear_priority(1'b1);
    test_bounce();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
